// File: rtl/alu_seq_pkg.sv
// Shared command encodings, FSM states and helpers for the sequential ALU.
package alu_seq_pkg;

  localparam logic [3:0] CMD_ADD  = 4'b0000;
  localparam logic [3:0] CMD_INC  = 4'b0001;
  localparam logic [3:0] CMD_SUB  = 4'b0010;
  localparam logic [3:0] CMD_DEC  = 4'b0011;
  localparam logic [3:0] CMD_MUL  = 4'b0100;
  localparam logic [3:0] CMD_DIV  = 4'b0101;
  localparam logic [3:0] CMD_SHR  = 4'b0110;
  localparam logic [3:0] CMD_SHL  = 4'b0111;
  localparam logic [3:0] CMD_AND  = 4'b1000;
  localparam logic [3:0] CMD_OR   = 4'b1001;
  localparam logic [3:0] CMD_INV  = 4'b1010;
  localparam logic [3:0] CMD_NAND = 4'b1011;
  localparam logic [3:0] CMD_NOR  = 4'b1100;
  localparam logic [3:0] CMD_XOR  = 4'b1101;
  localparam logic [3:0] CMD_XNOR = 4'b1110;
  localparam logic [3:0] CMD_BUF  = 4'b1111;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

  typedef enum logic {MD_MUL, MD_DIV} md_mode_t;

  function automatic logic is_multicycle(input logic [3:0] cmd);
    return (cmd == CMD_MUL) || (cmd == CMD_DIV);
  endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Shared iterative engine: shift-add multiply and restoring divide, one bit per clock.
module alu_seq_muldiv
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  md_mode_t           mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder
);

  logic [WIDTH-1:0] acc, sr, opb;
  logic [WIDTH-1:0] acc_next, sr_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH+1:0] trial;

  // acc:sr is the partial product (multiply) or remainder:dividend/quotient (divide)
  always_comb begin
    add_sum = {1'b0, acc} + (sr[0] ? {1'b0, opb} : '0);
    trial   = {1'b0, acc, sr[WIDTH-1]} - {2'b00, opb};
    if (mode == MD_MUL) begin
      acc_next = add_sum[WIDTH:1];
      sr_next  = {add_sum[0], sr[WIDTH-1:1]};
    end else if (trial[WIDTH+1]) begin
      acc_next = {acc[WIDTH-2:0], sr[WIDTH-1]};
      sr_next  = {sr[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = trial[WIDTH-1:0];
      sr_next  = {sr[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      sr  <= '0;
      opb <= '0;
      cnt <= '0;
    end else if (load) begin
      acc <= '0;
      sr  <= a;
      opb <= b;
      cnt <= CNT_W'(WIDTH);
    end else if (cnt != '0) begin
      acc <= acc_next;
      sr  <= sr_next;
      cnt <= cnt - 1'b1;
    end
  end

  // Results are the post-step values so the final iteration can be captured directly
  assign last      = (cnt == CNT_W'(1));
  assign product   = {acc_next, sr_next};
  assign quotient  = sr_next;
  assign remainder = acc_next;

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU with start/busy/done handshake, registered result and flags.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               start,
  input  logic [3:0]         command,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] y,
  output logic               zero,
  output logic               carry,
  output logic               dbz
);

  localparam int PAD = WIDTH - 1;

  state_t state, state_next;
  md_mode_t mode;
  logic [2*WIDTH-1:0] y_reg, y_next, op_res, product;
  logic [WIDTH-1:0] quotient, remainder, addend;
  logic [WIDTH:0] sum, diff;
  logic carry_reg, dbz_reg, zero_reg, done_reg;
  logic op_carry, op_dbz, res_carry, res_dbz;
  logic write, load, last;

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .last      (last),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // INC/DEC share the ADD/SUB adder with a constant-one operand
  always_comb begin
    op_res   = '0;
    op_carry = 1'b0;
    op_dbz   = 1'b0;
    addend   = (command == CMD_INC || command == CMD_DEC) ? WIDTH'(1) : b;
    sum      = {1'b0, a} + {1'b0, addend};
    diff     = {1'b0, a} - {1'b0, addend};
    case (command)
      CMD_ADD, CMD_INC: begin
        op_res   = {{PAD{1'b0}}, sum};
        op_carry = sum[WIDTH];
      end
      CMD_SUB, CMD_DEC: begin
        op_res   = {{PAD{1'b0}}, diff};
        op_carry = diff[WIDTH];
      end
      CMD_DIV: begin
        op_res = {a, {WIDTH{1'b1}}};
        op_dbz = 1'b1;
      end
      CMD_SHR:  op_res = {{WIDTH{1'b0}}, 1'b0, a[WIDTH-1:1]};
      CMD_SHL:  op_res = {{PAD{1'b0}}, a, 1'b0};
      CMD_AND:  op_res = {{WIDTH{1'b0}}, a & b};
      CMD_OR:   op_res = {{WIDTH{1'b0}}, a | b};
      CMD_INV:  op_res = {{WIDTH{1'b0}}, ~a};
      CMD_NAND: op_res = {{WIDTH{1'b0}}, ~(a & b)};
      CMD_NOR:  op_res = {{WIDTH{1'b0}}, ~(a | b)};
      CMD_XOR:  op_res = {{WIDTH{1'b0}}, a ^ b};
      CMD_XNOR: op_res = {{WIDTH{1'b0}}, ~(a ^ b)};
      CMD_BUF:  op_res = {{WIDTH{1'b0}}, a};
      default:  op_res = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    write      = 1'b0;
    y_next     = op_res;
    res_carry  = op_carry;
    res_dbz    = op_dbz;
    mode       = (state == ST_DIV) ? MD_DIV : MD_MUL;
    case (state)
      ST_IDLE: begin
        if (start && en) begin
          if (is_multicycle(command) && !(command == CMD_DIV && b == '0)) begin
            load       = 1'b1;
            state_next = (command == CMD_MUL) ? ST_MUL : ST_DIV;
          end else begin
            write = 1'b1;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (last) begin
          write      = 1'b1;
          y_next     = (state == ST_MUL) ? product : {remainder, quotient};
          res_carry  = 1'b0;
          res_dbz    = 1'b0;
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      y_reg     <= '0;
      zero_reg  <= 1'b1;
      carry_reg <= 1'b0;
      dbz_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state    <= state_next;
      done_reg <= write;
      if (write) begin
        y_reg     <= y_next;
        zero_reg  <= (y_next == '0);
        carry_reg <= res_carry;
        dbz_reg   <= res_dbz;
      end
    end
  end

  // The stored result survives en low; only the visible outputs are masked
  assign busy  = (state == ST_MUL) || (state == ST_DIV);
  assign done  = done_reg;
  assign y     = en ? y_reg : '0;
  assign zero  = en & zero_reg;
  assign carry = en & carry_reg;
  assign dbz   = en & dbz_reg;

endmodule
